// File: rtl/stage_sequencer.sv
// rtl/stage_sequencer.sv - multi-cycle stage sequencing FSM with retire counter and memory timeout
module stage_sequencer #(
    parameter int INSTRET_WIDTH = 32,
    parameter int MEM_TIMEOUT   = 16,
    parameter int TIMER_WIDTH   = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     run,
    input  logic                     IF_kick_up,
    input  logic                     Controller_kick_up,
    input  logic                     Controller_memread,
    input  logic                     Controller_memwrite,
    input  logic                     Controller_regwrite,
    input  logic                     Controller_branch,
    input  logic                     mem_ready,
    output logic                     fetch_req,
    output logic                     EX_kick_up,
    output logic                     mem_req,
    output logic                     WB_kick_up,
    output logic                     pc_update,
    output logic                     pc_sel_branch,
    output logic [INSTRET_WIDTH-1:0] instret,
    output logic                     mem_timeout,
    output logic [2:0]               state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_RETIRE = 3'd6,
        S_ERROR  = 3'd7
    } state_t;

    // Last cycle of MEM that may still be rescued by mem_ready
    localparam logic [TIMER_WIDTH-1:0] TIMER_LIMIT = TIMER_WIDTH'(MEM_TIMEOUT - 1);

    state_t                 state_q;
    state_t                 state_d;
    logic                   memread_q;
    logic                   memwrite_q;
    logic                   regwrite_q;
    logic                   branch_q;
    logic [TIMER_WIDTH-1:0] wait_q;

    assign state = state_q;

    // Next-state selection; inputs only matter in the state that consumes them
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (run) state_d = S_FETCH;
            S_FETCH:  if (IF_kick_up) state_d = S_DECODE;
            S_DECODE: if (Controller_kick_up) state_d = S_EXEC;
            S_EXEC: begin
                if (memread_q || memwrite_q) state_d = S_MEM;
                else if (regwrite_q)         state_d = S_WB;
                else                         state_d = S_RETIRE;
            end
            S_MEM: begin
                // A completion on the limit cycle takes priority over the timeout
                if (mem_ready)                  state_d = (memread_q && regwrite_q) ? S_WB : S_RETIRE;
                else if (wait_q == TIMER_LIMIT) state_d = S_ERROR;
            end
            S_WB:     state_d = S_RETIRE;
            S_RETIRE: state_d = run ? S_FETCH : S_IDLE;
            S_ERROR:  state_d = S_ERROR;
            default:  state_d = S_IDLE;
        endcase
    end

    // State, captured decode flags, wait counter, retire count and registered Moore outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            memread_q     <= 1'b0;
            memwrite_q    <= 1'b0;
            regwrite_q    <= 1'b0;
            branch_q      <= 1'b0;
            wait_q        <= '0;
            instret       <= '0;
            fetch_req     <= 1'b0;
            EX_kick_up    <= 1'b0;
            mem_req       <= 1'b0;
            WB_kick_up    <= 1'b0;
            pc_update     <= 1'b0;
            pc_sel_branch <= 1'b0;
            mem_timeout   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE && Controller_kick_up) begin
                memread_q  <= Controller_memread;
                memwrite_q <= Controller_memwrite;
                regwrite_q <= Controller_regwrite;
                branch_q   <= Controller_branch;
            end
            // Counter only runs while staying in MEM; any entry or exit leaves it at zero
            if (state_q == S_MEM && state_d == S_MEM) wait_q <= wait_q + 1'b1;
            else                                      wait_q <= '0;
            if (state_q == S_RETIRE) instret <= instret + 1'b1;
            // Outputs are decoded from the state being entered so they line up with it
            fetch_req     <= (state_d == S_FETCH);
            EX_kick_up    <= (state_d == S_EXEC);
            mem_req       <= (state_d == S_MEM);
            WB_kick_up    <= (state_d == S_WB);
            pc_update     <= (state_d == S_RETIRE);
            pc_sel_branch <= (state_d == S_RETIRE) && branch_q;
            mem_timeout   <= (state_d == S_ERROR);
        end
    end

endmodule

// File: tb/tb_stage_sequencer.sv
// tb/tb_stage_sequencer.sv - scoreboard bench for stage_sequencer
module tb_stage_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       run = 1'b0;
    logic       IF_kick_up = 1'b0;
    logic       Controller_kick_up = 1'b0;
    logic       Controller_memread = 1'b0;
    logic       Controller_memwrite = 1'b0;
    logic       Controller_regwrite = 1'b0;
    logic       Controller_branch = 1'b0;
    logic       mem_ready = 1'b0;
    logic       fetch_req, EX_kick_up, mem_req, WB_kick_up, pc_update, pc_sel_branch, mem_timeout;
    logic [3:0] instret;
    logic [2:0] state;

    stage_sequencer #(.INSTRET_WIDTH(4), .MEM_TIMEOUT(16), .TIMER_WIDTH(5)) dut (
        .clk(clk), .reset(reset), .run(run),
        .IF_kick_up(IF_kick_up), .Controller_kick_up(Controller_kick_up),
        .Controller_memread(Controller_memread), .Controller_memwrite(Controller_memwrite),
        .Controller_regwrite(Controller_regwrite), .Controller_branch(Controller_branch),
        .mem_ready(mem_ready), .fetch_req(fetch_req), .EX_kick_up(EX_kick_up),
        .mem_req(mem_req), .WB_kick_up(WB_kick_up), .pc_update(pc_update),
        .pc_sel_branch(pc_sel_branch), .instret(instret), .mem_timeout(mem_timeout),
        .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        int       cycles;
        int       mem_cycles;
        int       wb_cycles;
        bit       sel;
        bit [7:0] mask;
        bit [3:0] count;
    } exp_t;

    exp_t     sb[$];
    int       n_checks = 0;
    int       n_fail = 0;
    bit [3:0] model_instret = 4'd0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_pulses();
        IF_kick_up = 1'b0;
        Controller_kick_up = 1'b0;
        mem_ready = 1'b0;
    endtask

    // Monitor: accumulates what the DUT did during an instruction and checks it at retire
    int       m_cyc = 0, m_ex = 0, m_wb = 0, m_mem = 0;
    bit [7:0] m_mask = 8'd0;
    bit       m_pend = 1'b0;
    bit [3:0] m_exp_count = 4'd0;

    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                m_cyc = 0; m_ex = 0; m_wb = 0; m_mem = 0; m_mask = 8'd0; m_pend = 1'b0;
            end else begin
                if (m_pend) begin
                    chk("instret", instret, m_exp_count);
                    m_pend = 1'b0;
                end
                if (state >= 3'd1 && state <= 3'd6) begin
                    m_cyc++;
                    m_mask[state] = 1'b1;
                    m_ex  += int'(EX_kick_up);
                    m_wb  += int'(WB_kick_up);
                    m_mem += int'(mem_req);
                end
                if (pc_update) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_retire", 1, 0);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        chk("latency", m_cyc, e.cycles);
                        chk("state_path", m_mask, e.mask);
                        chk("ex_pulses", m_ex, 1);
                        chk("wb_pulses", m_wb, e.wb_cycles);
                        chk("mem_req_cycles", m_mem, e.mem_cycles);
                        chk("pc_sel_branch", pc_sel_branch, e.sel);
                        m_pend = 1'b1;
                        m_exp_count = e.count;
                    end
                    m_cyc = 0; m_ex = 0; m_wb = 0; m_mem = 0; m_mask = 8'd0;
                end
            end
        end
    end

    // Issue one instruction; expected behaviour comes from the stage rules, not the DUT
    task automatic run_instr(input bit mr, input bit mw, input bit rw, input bit br,
                             input int ifd, input int decd, input int memd,
                             input bit drop_run, input bit spur);
        exp_t e;
        bit   is_mem, is_wb, done;
        int   cf, cd, cm;
        is_mem = mr || mw;
        is_wb  = rw && (!is_mem || mr);
        e.cycles     = (ifd + 1) + (decd + 1) + 1 + (is_mem ? memd + 1 : 0) + (is_wb ? 1 : 0) + 1;
        e.mem_cycles = is_mem ? memd + 1 : 0;
        e.wb_cycles  = is_wb ? 1 : 0;
        e.sel        = br;
        e.mask       = 8'h4E | (is_mem ? 8'h10 : 8'h00) | (is_wb ? 8'h20 : 8'h00);
        model_instret = model_instret + 4'd1;
        e.count      = model_instret;
        sb.push_back(e);
        run = 1'b1;
        cf = 0; cd = 0; cm = 0; done = 1'b0;
        for (int g = 0; g < 200 && !done; g++) begin
            @(negedge clk);
            clear_pulses();
            Controller_memread  = 1'($urandom);
            Controller_memwrite = 1'($urandom);
            Controller_regwrite = 1'($urandom);
            Controller_branch   = 1'($urandom);
            case (state)
                3'd1: begin
                    if (cf == ifd) IF_kick_up = 1'b1;
                    cf++;
                end
                3'd2: begin
                    if (cd == decd) begin
                        Controller_kick_up  = 1'b1;
                        Controller_memread  = mr;
                        Controller_memwrite = mw;
                        Controller_regwrite = rw;
                        Controller_branch   = br;
                    end
                    if (spur) begin
                        IF_kick_up = 1'b1;
                        mem_ready  = 1'b1;
                    end
                    cd++;
                end
                3'd3: begin
                    if (drop_run) run = 1'b0;
                    if (spur) Controller_kick_up = 1'b1;
                end
                3'd4: begin
                    if (cm == memd) mem_ready = 1'b1;
                    cm++;
                end
                3'd5: if (spur) Controller_kick_up = 1'b1;
                3'd6: done = 1'b1;
                default: ;
            endcase
        end
        if (!done) chk("driver_timeout", 0, 1);
        if (drop_run) begin
            @(negedge clk);
            clear_pulses();
            chk("idle_after_drop", state, 0);
        end
    endtask

    // Drive a load into MEM and stop there, leaving the caller at a negedge in MEM cycle 1
    task automatic load_to_mem();
        run = 1'b1;
        for (int g = 0; g < 50 && state != 3'd4; g++) begin
            @(negedge clk);
            clear_pulses();
            if (state == 3'd1) IF_kick_up = 1'b1;
            else if (state == 3'd2) begin
                Controller_kick_up  = 1'b1;
                Controller_memread  = 1'b1;
                Controller_memwrite = 1'b0;
                Controller_regwrite = 1'b1;
                Controller_branch   = 1'b0;
            end
        end
        chk("reached_mem", state, 4);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        run = 1'b0;
        clear_pulses();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_instret = 4'd0;
    endtask

    initial begin
        int memc;
        do_reset();
        chk("reset_state", state, 0);
        chk("reset_fetch_req", fetch_req, 0);
        chk("reset_mem_req", mem_req, 0);
        chk("reset_pc_update", pc_update, 0);
        chk("reset_instret", instret, 0);
        chk("reset_mem_timeout", mem_timeout, 0);

        // ALU, load with 3 MEM cycles, store, jump, load rescued on the 16th MEM cycle
        run_instr(0, 0, 1, 0, 0, 0, 0, 0, 0);
        run_instr(1, 0, 1, 0, 0, 0, 2, 0, 0);
        run_instr(0, 1, 0, 0, 0, 0, 0, 0, 0);
        run_instr(0, 0, 0, 1, 0, 0, 0, 0, 0);
        run_instr(1, 0, 1, 0, 0, 0, 15, 0, 0);
        run_instr(1, 1, 1, 0, 1, 1, 3, 0, 1);
        run_instr(0, 0, 1, 0, 0, 0, 0, 1, 1);

        for (int i = 0; i < 150; i++) begin
            run_instr(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 15)), ($urandom % 6) == 0 || i == 149,
                      ($urandom % 3) == 0);
        end
        repeat (2) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);

        // Memory never answers: error after exactly 16 MEM cycles, then stuck
        do_reset();
        load_to_mem();
        clear_pulses();
        memc = 0;
        while (state == 3'd4 && memc < 40) begin
            memc++;
            @(negedge clk);
        end
        chk("timeout_mem_cycles", memc, 16);
        chk("error_state", state, 7);
        chk("error_flag", mem_timeout, 1);
        chk("error_mem_req", mem_req, 0);
        chk("error_fetch_req", fetch_req, 0);
        repeat (4) @(negedge clk);
        chk("error_sticky_state", state, 7);
        chk("error_sticky_flag", mem_timeout, 1);
        chk("error_pc_update", pc_update, 0);

        // Reset mid-MEM drops the request before any clock edge
        do_reset();
        chk("error_cleared", mem_timeout, 0);
        load_to_mem();
        clear_pulses();
        @(negedge clk);
        chk("mem_req_before_reset", mem_req, 1);
        #2 reset = 1'b1;
        #1;
        chk("async_mem_req_drop", mem_req, 0);
        chk("async_state_idle", state, 0);
        do_reset();

        // 16 retirements on a 4-bit counter: the last one wraps to zero
        for (int i = 0; i < 16; i++) run_instr(0, 0, 1, 0, 0, 0, 0, i == 15, 0);
        repeat (2) @(negedge clk);
        chk("instret_wrapped", instret, 0);
        chk("final_scoreboard_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
